// File: rtl/gpu_vram_readback.sv
// gpu_vram_readback: VRAM->CPU rectangle readback engine (GP0 C0h), feeding GPUREAD.
// Walks a rect of 16-bit pixels, issues pipelined VRAM reads, packs pixel pairs
// into 32-bit words and buffers them in a show-ahead output FIFO.
// Optional macro GPU_RDBK_PERF_EN adds the stall_cnt_o fetch-stall counter.
module gpu_vram_readback #(
  parameter int unsigned VRAM_LAT    = 2,
  parameter int unsigned OFIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [9:0]  src_x_i,
  input  logic [8:0]  src_y_i,
  input  logic [9:0]  size_w_i,
  input  logic [8:0]  size_h_i,
  output logic        vram_req_o,
  output logic [19:0] vram_addr_o,
  input  logic        vram_gnt_i,
  input  logic [15:0] vram_rdata_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        done_o
`ifdef GPU_RDBK_PERF_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(OFIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Rect parameters and walk position
  logic [9:0]  x0_q, x0_d, wm1_q, wm1_d, col_q, col_d;
  logic [8:0]  y0_q, y0_d, hm1_q, hm1_d, row_q, row_d;
  logic        par_q, par_d;

  // Request port
  logic        req_q, req_d;
  logic [19:0] addr_q, addr_d;

  // Return valid pipe with halfword parity and last-halfword tags
  logic [VRAM_LAT-1:0] pv_q, pv_d, pp_q, pp_d, pl_q, pl_d;

  // Packing stage
  logic [15:0] lo_q, lo_d;
  logic        push_q, push_d, push_last_q, push_last_d;
  logic [31:0] word_q, word_d;

  // Output FIFO
  logic [31:0] mem_q [OFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d, rsv_q, rsv_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;

  // Control strobes
  logic start_c, in_fetch_c, acc_c, last_acc_c, alloc_c, pop_c, wr_c, credit_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: abort wins, final pushed word ends the transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)             state_d = S_FETCH;
      S_FETCH: if (last_acc_c)          state_d = S_DRAIN;
      S_DRAIN: if (push_q && push_last_q) state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // FSM outputs: control strobes derived from the current state
  always_comb begin
    start_c    = 1'b0;
    in_fetch_c = 1'b0;
    acc_c      = 1'b0;
    last_acc_c = 1'b0;
    start_c    = (state_q == S_IDLE) && start_i && !abort_i;
    in_fetch_c = (state_q == S_FETCH);
    acc_c      = in_fetch_c && req_q && vram_gnt_i;
    last_acc_c = acc_c && (col_q == wm1_q) && (row_q == hm1_q);
  end

  // Rect walk, credit check and registered request/address generation
  always_comb begin
    x0_d    = x0_q;
    y0_d    = y0_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    col_d   = col_q;
    row_d   = row_q;
    par_d   = par_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    alloc_c = acc_c && !par_q;
    pop_c   = rd_en_i && rd_valid_q;
    rsv_d   = rsv_q + CW'(alloc_c) - CW'(pop_c);
    if (start_c) begin
      x0_d   = src_x_i;
      y0_d   = src_y_i;
      wm1_d  = size_w_i - 10'd1;
      hm1_d  = size_h_i - 9'd1;
      col_d  = 10'd0;
      row_d  = 9'd0;
      par_d  = 1'b0;
      addr_d = {1'b0, src_y_i, src_x_i};
    end else if (acc_c) begin
      par_d = !par_q;
      if (col_q == wm1_q) begin
        col_d = 10'd0;
        row_d = row_q + 9'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    // An odd halfword completes an already-reserved word, so only even ones need a free slot
    credit_c = par_d || (rsv_d < CW'(OFIFO_DEPTH));
    if (in_fetch_c) begin
      if (req_q && !vram_gnt_i) begin
        req_d = 1'b1;
      end else begin
        addr_d = {1'b0, 9'(y0_q + row_d), 10'(x0_q + col_d)};
        req_d  = !last_acc_c && credit_c;
      end
    end
    if (abort_i) begin
      req_d = 1'b0;
      rsv_d = '0;
    end
  end

  // Return pipe: tracks accepted requests until their data arrives
  always_comb begin
    pv_d    = '0;
    pp_d    = pp_q;
    pl_d    = pl_q;
    pv_d[0] = acc_c && !abort_i;
    pp_d[0] = par_q;
    pl_d[0] = last_acc_c;
    for (int unsigned i = 1; i < VRAM_LAT; i++) begin
      pv_d[i] = pv_q[i-1] && !abort_i;
      pp_d[i] = pp_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  // Packing: even halfword to the low half, odd (or final odd-count) pushes the word
  always_comb begin
    lo_d        = lo_q;
    push_d      = 1'b0;
    push_last_d = 1'b0;
    word_d      = word_q;
    if (!abort_i && pv_q[VRAM_LAT-1]) begin
      if (!pp_q[VRAM_LAT-1]) begin
        lo_d = vram_rdata_i;
        if (pl_q[VRAM_LAT-1]) begin
          push_d      = 1'b1;
          push_last_d = 1'b1;
          word_d      = {16'h0000, vram_rdata_i};
        end
      end else begin
        push_d      = 1'b1;
        push_last_d = pl_q[VRAM_LAT-1];
        word_d      = {vram_rdata_i, lo_q};
      end
    end
    done_d = push_d && push_last_d;
  end

  // Output FIFO pointers, count and registered show-ahead head
  always_comb begin
    wr_c      = push_q && !abort_i;
    wr_ptr_d  = wr_ptr_q + PW'(wr_c);
    rd_ptr_d  = rd_ptr_q + PW'(pop_c);
    fcnt_d    = fcnt_q + CW'(wr_c) - CW'(pop_c);
    rd_data_d = mem_q[rd_ptr_d];
    if (wr_c && (rd_ptr_d == wr_ptr_q)) rd_data_d = word_q;
    if (fcnt_d == '0) rd_data_d = 32'h0;
    if (abort_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fcnt_d    = '0;
      rd_data_d = 32'h0;
    end
    rd_valid_d = (fcnt_d != '0);
    busy_d     = (state_d != S_IDLE);
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OFIFO_DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (wr_c) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q        <= '0;
      y0_q        <= '0;
      wm1_q       <= '0;
      hm1_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      par_q       <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      pv_q        <= '0;
      pp_q        <= '0;
      pl_q        <= '0;
      lo_q        <= '0;
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      rsv_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      wm1_q       <= wm1_d;
      hm1_q       <= hm1_d;
      col_q       <= col_d;
      row_q       <= row_d;
      par_q       <= par_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      pv_q        <= pv_d;
      pp_q        <= pp_d;
      pl_q        <= pl_d;
      lo_q        <= lo_d;
      push_q      <= push_d;
      push_last_q <= push_last_d;
      word_q      <= word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      rsv_q       <= rsv_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vram_req_o  = req_q;
  assign vram_addr_o = addr_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef GPU_RDBK_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_c;

  // Fetch-stall counter: blocked by missing credit or by an ungranted request
  always_comb begin
    stall_c = in_fetch_c &&
              ((req_q && !vram_gnt_i) || (!req_q && !(par_q || (rsv_q < CW'(OFIFO_DEPTH)))));
    stall_d = stall_q;
    if (stall_c && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (start_c || abort_i) stall_d = 16'h0;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'h0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
